timer_counter: RTL and testbench

Parametrised 8051-class timer/counter for the MCU core's peripheral block. Holds its own TH/TL count registers, so the SFR file no longer owns them. Supports the four classic modes, generalised in width:
- 13-bit-style prescaled
- full 2×HW-bit
- HW-bit auto-reload
- split dual counters

Counts either the machine-cycle tick or falling edges on an external pin, with gating, an overflow flag, and SFR write access.

---
 rtl/timer_counter.sv | 138 +++++++++++++
 tb/tb_timer_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: 8051-class timer/counter with TH/TL count registers, four
// modes (prescaled, 2xHW, HW auto-reload, split), tick/pin counting, gating,
// sticky overflow flags and SFR writes.
// Optional feature: define TIMER_MODE3_EN to enable mode 11 split counters;
// otherwise mode 11 halts counting and tf_h is tied low.
module timer_counter #(
  parameter int unsigned HW     = 8,
  parameter int unsigned TL_PRE = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          t_pin,
  input  logic          int_pin,
  input  logic          tr,
  input  logic          tr_h,
  input  logic [3:0]    tmod,
  input  logic          wr_l,
  input  logic          wr_h,
  input  logic [HW-1:0] wr_data,
  input  logic          tf_clr,
  input  logic          tf_h_clr,
  output logic [HW-1:0] th,
  output logic [HW-1:0] tl,
  output logic          tf,
  output logic          tf_h
);

  localparam int unsigned CW0 = HW + TL_PRE;
  localparam int unsigned CW1 = 2 * HW;
  localparam logic [HW-1:0] PRE_MASK = {HW{1'b1}} >> (HW - TL_PRE);

  logic          gate, ct;
  logic [1:0]    mode;
  logic          run, cnt_event, any_wr;
  logic          pin_q;
  logic [CW0-1:0] c0, c0_inc;
  logic [CW1-1:0] c1, c1_inc;
  logic [HW-1:0] tl_inc;
  logic [HW-1:0] th_n, tl_n;
  logic          tf_set, tf_n;

  assign {gate, ct, mode} = tmod;
  assign run       = tr & (~gate | int_pin);
  assign cnt_event = tick & run & (ct ? (pin_q & ~t_pin) : 1'b1);
  assign any_wr    = wr_l | wr_h;

  assign c0     = {th, tl[TL_PRE-1:0]};
  assign c0_inc = c0 + CW0'(1);
  assign c1     = {th, tl};
  assign c1_inc = c1 + CW1'(1);
  assign tl_inc = tl + HW'(1);

`ifdef TIMER_MODE3_EN
  logic [HW-1:0] th_inc;
  logic          tfh_set, tfh_n;
  assign th_inc = th + HW'(1);
`else
  logic unused_mode3;
  assign unused_mode3 = tr_h ^ tf_h_clr;
  assign tf_h = 1'b0;
`endif

  // Next-state for count registers and flags; a write blocks all counting.
  always_comb begin
    th_n   = th;
    tl_n   = tl;
    tf_set = 1'b0;
`ifdef TIMER_MODE3_EN
    tfh_set = 1'b0;
`endif
    if (any_wr) begin
      if (wr_l) tl_n = wr_data;
      if (wr_h) th_n = wr_data;
    end else begin
      if (cnt_event) begin
        case (mode)
          2'b00: begin
            th_n   = c0_inc[CW0-1:TL_PRE];
            tl_n   = (tl & ~PRE_MASK) | (HW'(c0_inc[TL_PRE-1:0]) & PRE_MASK);
            tf_set = &c0;
          end
          2'b01: begin
            {th_n, tl_n} = c1_inc;
            tf_set       = &c1;
          end
          2'b10: begin
            if (&tl) begin
              tl_n   = th;
              tf_set = 1'b1;
            end else begin
              tl_n = tl_inc;
            end
          end
          default: begin
`ifdef TIMER_MODE3_EN
            tl_n   = tl_inc;
            tf_set = &tl;
`endif
          end
        endcase
      end
`ifdef TIMER_MODE3_EN
      // Split-mode TH runs off tick and tr_h only.
      if (mode == 2'b11 && tick && tr_h) begin
        th_n    = th_inc;
        tfh_set = &th;
      end
`endif
    end
    tf_n = tf_set | (tf & ~tf_clr);
`ifdef TIMER_MODE3_EN
    tfh_n = tfh_set | (tf_h & ~tf_h_clr);
`endif
  end

  // State registers; pin_q tracks t_pin on tick edges for falling-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      th    <= '0;
      tl    <= '0;
      tf    <= 1'b0;
      pin_q <= 1'b1;
`ifdef TIMER_MODE3_EN
      tf_h  <= 1'b0;
`endif
    end else begin
      th <= th_n;
      tl <= tl_n;
      tf <= tf_n;
      if (tick) pin_q <= t_pin;
`ifdef TIMER_MODE3_EN
      tf_h <= tfh_n;
`endif
    end
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter (HW=8, TL_PRE=5).
module tb_timer_counter;

  logic       clk = 1'b0;
  logic       clk_run = 1'b1;
  logic       rst_n, tick, t_pin, int_pin, tr, tr_h;
  logic [3:0] tmod;
  logic       wr_l, wr_h, tf_clr, tf_h_clr;
  logic [7:0] wr_data;
  logic [7:0] th, tl;
  logic       tf, tf_h;

  int errs   = 0;
  int checks = 0;

  timer_counter #(.HW(8), .TL_PRE(5)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .t_pin(t_pin), .int_pin(int_pin),
    .tr(tr), .tr_h(tr_h), .tmod(tmod), .wr_l(wr_l), .wr_h(wr_h),
    .wr_data(wr_data), .tf_clr(tf_clr), .tf_h_clr(tf_h_clr),
    .th(th), .tl(tl), .tf(tf), .tf_h(tf_h)
  );

  // Free-running clock that can be parked low.
  always #5 clk = clk_run ? ~clk : 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_regs(input logic [7:0] h, input logic [7:0] l);
    wr_h = 1'b1; wr_data = h; step(1);
    wr_h = 1'b0; wr_l = 1'b1; wr_data = l; step(1);
    wr_l = 1'b0;
  endtask

  task automatic clr_tf();
    tf_clr = 1'b1; step(1); tf_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b1; t_pin = 1'b0; int_pin = 1'b0; tr = 1'b0;
    tr_h = 1'b0; tmod = 4'b0001; wr_l = 1'b0; wr_h = 1'b0; wr_data = 8'h00;
    tf_clr = 1'b0; tf_h_clr = 1'b0;
    #3;
    chk("rst_th", 32'(th), 32'h00);
    chk("rst_tl", 32'(tl), 32'h00);
    chk("rst_tf", 32'(tf), 32'h0);
    chk("rst_tfh", 32'(tf_h), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Mode 01: 16-bit wrap
    tmod = 4'b0001; wr_regs(8'hFF, 8'hFE);
    tr = 1'b1; step(1);
    chk("m1_tl_ff", 32'(tl), 32'hFF);
    chk("m1_tf_pre", 32'(tf), 32'h0);
    step(1);
    chk("m1_th", 32'(th), 32'h00);
    chk("m1_tl", 32'(tl), 32'h00);
    chk("m1_tf", 32'(tf), 32'h1);
    tr = 1'b0; clr_tf();
    chk("m1_tfclr", 32'(tf), 32'h0);

    // Tick gating and timer gate
    wr_regs(8'h00, 8'h10);
    tr = 1'b1; tick = 1'b0; step(3);
    chk("tick0_tl", 32'(tl), 32'h10);
    tick = 1'b1; step(1);
    chk("tick1_tl", 32'(tl), 32'h11);
    tmod = 4'b1001; int_pin = 1'b0; step(2);
    chk("gate_hold", 32'(tl), 32'h11);
    int_pin = 1'b1; step(2);
    chk("gate_run", 32'(tl), 32'h13);
    tr = 1'b0; int_pin = 1'b0;

    // Mode 10: auto-reload
    tmod = 4'b0010; wr_regs(8'hC8, 8'hFF);
    tr = 1'b1; step(1);
    chk("m2_tl_reload", 32'(tl), 32'hC8);
    chk("m2_tf", 32'(tf), 32'h1);
    chk("m2_th", 32'(th), 32'hC8);
    clr_tf();
    chk("m2_tfclr", 32'(tf), 32'h0);
    chk("m2_tl_c9", 32'(tl), 32'hC9);
    step(54);
    chk("m2_tl_ff", 32'(tl), 32'hFF);
    chk("m2_tf_pre", 32'(tf), 32'h0);
    step(1);
    chk("m2_tl_again", 32'(tl), 32'hC8);
    chk("m2_tf_again", 32'(tf), 32'h1);
    tr = 1'b0; clr_tf();

    // Mode 00: 13-bit prescaled
    tmod = 4'b0000; wr_regs(8'hFF, 8'hFF);
    tr = 1'b1; step(1);
    chk("m0_th", 32'(th), 32'h00);
    chk("m0_tl", 32'(tl), 32'hE0);
    chk("m0_tf", 32'(tf), 32'h1);
    tr = 1'b0; clr_tf();
    wr_regs(8'h12, 8'h5F);
    tr = 1'b1; step(1);
    chk("m0_carry_th", 32'(th), 32'h13);
    chk("m0_carry_tl", 32'(tl), 32'h40);
    chk("m0_carry_tf", 32'(tf), 32'h0);
    tr = 1'b0;

    // Mode 01 counter with gate
    tmod = 4'b1101; wr_regs(8'h00, 8'h00);
    tr = 1'b1; int_pin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t_pin = 1'b1; step(1); t_pin = 1'b0; step(1);
    end
    chk("ct_gated", 32'(tl), 32'h00);
    int_pin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t_pin = 1'b1; step(1); t_pin = 1'b0; step(1);
    end
    chk("ct_3edges", 32'(tl), 32'h03);
    step(3);
    chk("ct_low_hold", 32'(tl), 32'h03);
    tr = 1'b0; int_pin = 1'b0;

    // Clear on overflow edge: set wins
    tmod = 4'b0001; wr_regs(8'hFF, 8'hFF);
    tr = 1'b1; tf_clr = 1'b1; step(1); tf_clr = 1'b0;
    chk("setwins_tf", 32'(tf), 32'h1);
    chk("setwins_tl", 32'(tl), 32'h00);
    tr = 1'b0; clr_tf();

    // Write in a counting cycle suppresses count and overflow
    wr_regs(8'hFF, 8'hFF);
    tr = 1'b1; wr_l = 1'b1; wr_data = 8'h55; step(1); wr_l = 1'b0;
    chk("wr_tl", 32'(tl), 32'h55);
    chk("wr_th", 32'(th), 32'hFF);
    chk("wr_tf", 32'(tf), 32'h0);
    wr_l = 1'b1; wr_h = 1'b1; wr_data = 8'hA5; step(1);
    wr_l = 1'b0; wr_h = 1'b0;
    chk("wr_both", 32'({th, tl}), 32'hA5A5);

    // Async reset with clock stopped
    step(2);
    tf_clr = 1'b0;
    clk_run = 1'b0; #20;
    rst_n = 1'b0; #2;
    chk("arst_th", 32'(th), 32'h00);
    chk("arst_tl", 32'(tl), 32'h00);
    chk("arst_tf", 32'(tf), 32'h0);
    #5; rst_n = 1'b1; tr = 1'b1; tmod = 4'b0101; t_pin = 1'b0;
    clk_run = 1'b1;
    step(1);
    chk("pinq_rst1", 32'(tl), 32'h01);
    tr = 1'b0;

    // Mode 11
    tmod = 4'b0011; wr_regs(8'hFF, 8'h10);
    tr_h = 1'b1; step(1); tr_h = 1'b0;
`ifdef TIMER_MODE3_EN
    chk("m3_th", 32'(th), 32'h00);
    chk("m3_tfh", 32'(tf_h), 32'h1);
    chk("m3_tl", 32'(tl), 32'h10);
    tf_h_clr = 1'b1; step(1); tf_h_clr = 1'b0;
    chk("m3_tfh_clr", 32'(tf_h), 32'h0);
`else
    chk("m3_th", 32'(th), 32'hFF);
    chk("m3_tfh", 32'(tf_h), 32'h0);
    chk("m3_tl", 32'(tl), 32'h10);
    tr = 1'b1; step(2); tr = 1'b0;
    chk("m3_halt_tl", 32'(tl), 32'h10);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
